// File: rtl/instr_fetch_seq_pkg.sv
// Shared X1 CPU constants: opcodes, operand types, instruction field slices
// and the sequencer state encoding.
package instr_fetch_seq_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 35;
  localparam int N8      = 8;
  localparam int N10     = 10;

  // Field bit positions, shared with the execute datapath
  localparam int OPC_HI  = 34;
  localparam int OPC_LO  = 32;
  localparam int FUNC_HI = 31;
  localparam int FUNC_LO = 28;
  localparam int OP1_HI  = 27;
  localparam int OP1_LO  = 18;
  localparam int OP2_HI  = 17;
  localparam int OP2_LO  = 8;
  localparam int TGT_HI  = 7;
  localparam int TGT_LO  = 0;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_MOV = 3'd1;
  localparam logic [2:0] OP_ACC = 3'd2;
  localparam logic [2:0] OP_ALU = 3'd3;
  localparam logic [2:0] OP_JMP = 3'd4;

  localparam logic [1:0] OT_NONE = 2'd0;
  localparam logic [1:0] OT_IMM  = 2'd1;
  localparam logic [1:0] OT_REG  = 2'd2;
  localparam logic [1:0] OT_MEM  = 2'd3;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_seq_if.sv
// ROM and execute-side signals of the fetch sequencer.
interface instr_fetch_seq_if;
  import instr_fetch_seq_pkg::*;

  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_data;
  logic               stall;
  logic               ex_ready;
  logic               jump_taken;
  logic [ADDR_W-1:0]  pc;
  logic               ir_valid;
  logic [2:0]         opcode;
  logic [3:0]         func;
  logic [1:0]         op1_type;
  logic [N8-1:0]      op1_val;
  logic [1:0]         op2_type;
  logic [N8-1:0]      op2_val;
  logic [N8-1:0]      target;

  modport master (
    output rom_addr, pc, ir_valid, opcode, func,
           op1_type, op1_val, op2_type, op2_val, target,
    input  rom_data, stall, ex_ready, jump_taken
  );

  modport slave (
    input  rom_addr, pc, ir_valid, opcode, func,
           op1_type, op1_val, op2_type, op2_val, target,
    output rom_data, stall, ex_ready, jump_taken
  );

endinterface

// File: rtl/instr_fetch_seq_decode.sv
// Combinational split of the instruction register into its fields,
// plus the NOP / JMP flags the sequencer branches on.
module instr_fetch_seq_decode
  import instr_fetch_seq_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output logic [2:0]         opcode,
  output logic [3:0]         func,
  output logic [1:0]         op1_type,
  output logic [N8-1:0]      op1_val,
  output logic [1:0]         op2_type,
  output logic [N8-1:0]      op2_val,
  output logic [N8-1:0]      target,
  output logic               is_nop,
  output logic               is_jmp
);

  logic [N10-1:0] op1_s;
  logic [N10-1:0] op2_s;

  assign op1_s    = ir[OP1_HI:OP1_LO];
  assign op2_s    = ir[OP2_HI:OP2_LO];
  assign opcode   = ir[OPC_HI:OPC_LO];
  assign func     = ir[FUNC_HI:FUNC_LO];
  assign op1_type = op1_s[N10-1:N8];
  assign op1_val  = op1_s[N8-1:0];
  assign op2_type = op2_s[N10-1:N8];
  assign op2_val  = op2_s[N8-1:0];
  assign target   = ir[TGT_HI:TGT_LO];

  // Undefined opcodes fall out as neither NOP nor JMP
  assign is_nop   = (opcode == OP_NOP);
  assign is_jmp   = (opcode == OP_JMP);

endmodule

// File: rtl/instr_fetch_seq.sv
// X1 program counter and fetch/decode sequencer: fetches from the async ROM,
// holds the word in IR and offers it to execute with a valid/ready handshake.
module instr_fetch_seq
  import instr_fetch_seq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'd0
) (
  input  logic              clock,
  input  logic              reset,
  instr_fetch_seq_if.master bus
);

  fetch_state_e       state_r;
  fetch_state_e       state_nxt_s;
  logic [ADDR_W-1:0]  pc_r;
  logic [ADDR_W-1:0]  pc_nxt_s;
  logic [INSTR_W-1:0] ir_r;
  logic               is_nop_s;
  logic               is_jmp_s;
  logic [N8-1:0]      target_s;

  instr_fetch_seq_decode u_decode (
    .ir       (ir_r),
    .opcode   (bus.opcode),
    .func     (bus.func),
    .op1_type (bus.op1_type),
    .op1_val  (bus.op1_val),
    .op2_type (bus.op2_type),
    .op2_val  (bus.op2_val),
    .target   (target_s),
    .is_nop   (is_nop_s),
    .is_jmp   (is_jmp_s)
  );

  assign bus.target   = target_s;
  assign bus.rom_addr = pc_r;
  assign bus.pc       = pc_r;
  assign bus.ir_valid = (state_r == ST_EXEC);

  // State, PC and IR registers; stall freezes every one of them
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_FETCH;
      pc_r    <= RESET_PC;
      ir_r    <= {INSTR_W{1'b0}};
    end else if (!bus.stall) begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      if (state_r == ST_FETCH) begin
        ir_r <= bus.rom_data;
      end else begin
        ir_r <= ir_r;
      end
    end else begin
      state_r <= state_r;
      pc_r    <= pc_r;
      ir_r    <= ir_r;
    end
  end

  // Next-state and next-PC selection
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    case (state_r)
      ST_FETCH: begin
        state_nxt_s = ST_DECODE;
      end
      ST_DECODE: begin
        if (is_nop_s) begin
          pc_nxt_s    = pc_r + 8'd1;
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (bus.ex_ready) begin
          state_nxt_s = ST_FETCH;
          if (is_jmp_s && bus.jump_taken) begin
            pc_nxt_s = target_s;
          end else begin
            pc_nxt_s = pc_r + 8'd1;
          end
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      default: begin
        state_nxt_s = ST_FETCH;
        pc_nxt_s    = pc_r;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq: ROM model, handshake, jumps, stall, reset.
module tb_instr_fetch_seq;
  import instr_fetch_seq_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [INSTR_W-1:0] rom_mem [256];
  logic               rom_ovr;
  logic [INSTR_W-1:0] rom_force;

  instr_fetch_seq_if bus ();

  instr_fetch_seq #(.RESET_PC(8'd0)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.rom_data = rom_ovr ? rom_force : rom_mem[bus.rom_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [INSTR_W-1:0] mk(input logic [2:0] opc, input logic [3:0] fn,
                                            input logic [1:0] t1, input logic [7:0] v1,
                                            input logic [1:0] t2, input logic [7:0] v2,
                                            input logic [7:0] tgt);
    return {opc, fn, t1, v1, t2, v2, tgt};
  endfunction

  initial begin
    checks         = 0;
    failures       = 0;
    reset          = 1'b1;
    rom_ovr        = 1'b0;
    rom_force      = 35'd0;
    bus.stall      = 1'b0;
    bus.ex_ready   = 1'b0;
    bus.jump_taken = 1'b0;
    for (int i = 0; i < 256; i++) rom_mem[i] = 35'd0;
    rom_mem[0]   = mk(OP_MOV, 4'h5, OT_IMM, 8'h12, OT_REG, 8'h34, 8'h56);
    rom_mem[7]   = mk(OP_JMP, 4'h0, OT_NONE, 8'h00, OT_NONE, 8'h00, 8'h04);
    rom_mem[8]   = mk(OP_ACC, 4'h3, OT_REG, 8'hA5, OT_IMM, 8'h5A, 8'h00);
    rom_mem[10]  = mk(OP_MOV, 4'h2, OT_MEM, 8'h01, OT_IMM, 8'h02, 8'h03);
    rom_mem[20]  = mk(OP_JMP, 4'h0, OT_NONE, 8'h00, OT_NONE, 8'h00, 8'd20);
    rom_mem[21]  = mk(3'd7, 4'hF, OT_IMM, 8'h11, OT_IMM, 8'h22, 8'h40);
    rom_mem[255] = mk(OP_MOV, 4'h1, OT_IMM, 8'hFF, OT_REG, 8'h00, 8'h99);

    // Reset state
    step(); step();
    chk("rst_pc",       64'(bus.pc), 64'd0);
    chk("rst_valid",    64'(bus.ir_valid), 64'd0);
    chk("rst_opcode",   64'(bus.opcode), 64'd0);
    chk("rst_target",   64'(bus.target), 64'd0);
    chk("rst_rom_addr", 64'(bus.rom_addr), 64'd0);

    // MOV at 0 followed by NOPs
    bus.ex_ready = 1'b1;
    reset = 1'b0;
    chk("mov_fetch_addr",  64'(bus.rom_addr), 64'd0);
    chk("mov_fetch_valid", 64'(bus.ir_valid), 64'd0);
    step();
    chk("mov_dec_valid",  64'(bus.ir_valid), 64'd0);
    chk("mov_dec_opcode", 64'(bus.opcode), 64'(OP_MOV));
    step();
    chk("mov_ex_valid", 64'(bus.ir_valid), 64'd1);
    chk("mov_func",     64'(bus.func), 64'h5);
    chk("mov_op1",      64'({bus.op1_type, bus.op1_val}), 64'({OT_IMM, 8'h12}));
    chk("mov_op2",      64'({bus.op2_type, bus.op2_val}), 64'({OT_REG, 8'h34}));
    chk("mov_target",   64'(bus.target), 64'h56);
    chk("mov_ex_pc",    64'(bus.pc), 64'd0);
    step();
    chk("nop_pc1", 64'(bus.pc), 64'd1);
    for (int k = 1; k < 4; k++) begin
      step();
      chk("nop_dec_pc",    64'(bus.pc), 64'(k));
      chk("nop_dec_valid", 64'(bus.ir_valid), 64'd0);
      step();
      chk("nop_next_pc",   64'(bus.pc), 64'(k + 1));
      chk("nop_valid",     64'(bus.ir_valid), 64'd0);
    end

    // NOPs 4..6 then JMP at 7, taken
    for (int k = 4; k < 7; k++) begin
      step(); step();
    end
    chk("jmp_fetch_pc", 64'(bus.pc), 64'd7);
    step(); step();
    chk("jmp_ex_valid",  64'(bus.ir_valid), 64'd1);
    chk("jmp_ex_opcode", 64'(bus.opcode), 64'(OP_JMP));
    bus.jump_taken = 1'b1;
    step();
    chk("jmp_taken_addr",  64'(bus.rom_addr), 64'd4);
    chk("jmp_taken_valid", 64'(bus.ir_valid), 64'd0);

    // Back around to 7, JMP not taken
    for (int k = 4; k < 7; k++) begin
      step(); step();
    end
    step(); step();
    bus.jump_taken = 1'b0;
    step();
    chk("jmp_not_taken_addr", 64'(bus.rom_addr), 64'd8);

    // ACC at 8 held for 5 cycles of ex_ready=0
    bus.ex_ready = 1'b0;
    step(); step();
    for (int i = 0; i < 6; i++) begin
      chk("acc_valid",  64'(bus.ir_valid), 64'd1);
      chk("acc_opcode", 64'(bus.opcode), 64'(OP_ACC));
      chk("acc_op1",    64'({bus.op1_type, bus.op1_val}), 64'({OT_REG, 8'hA5}));
      chk("acc_pc",     64'(bus.pc), 64'd8);
      if (i == 5) bus.ex_ready = 1'b1;
      step();
    end
    chk("acc_after_pc",    64'(bus.pc), 64'd9);
    chk("acc_after_valid", 64'(bus.ir_valid), 64'd0);

    // Stall for 3 edges during FETCH at 9 with the ROM word changing
    rom_ovr   = 1'b1;
    bus.stall = 1'b1;
    rom_force = mk(OP_MOV, 4'h1, OT_IMM, 8'h01, OT_IMM, 8'h01, 8'h11);
    step();
    chk("stall_pc",    64'(bus.pc), 64'd9);
    chk("stall_valid", 64'(bus.ir_valid), 64'd0);
    rom_force = mk(OP_JMP, 4'h2, OT_IMM, 8'h02, OT_IMM, 8'h02, 8'h22);
    step();
    rom_force = mk(OP_ALU, 4'h3, OT_IMM, 8'h03, OT_IMM, 8'h03, 8'h33);
    step();
    bus.stall = 1'b0;
    rom_force = mk(OP_ACC, 4'h9, OT_MEM, 8'h44, OT_REG, 8'h55, 8'h77);
    step();
    rom_force = mk(OP_JMP, 4'hE, OT_MEM, 8'hEE, OT_MEM, 8'hEE, 8'hEE);
    chk("stall_cap_opcode", 64'(bus.opcode), 64'(OP_ACC));
    chk("stall_cap_func",   64'(bus.func), 64'h9);
    chk("stall_cap_target", 64'(bus.target), 64'h77);
    step();
    chk("stall_ex_valid", 64'(bus.ir_valid), 64'd1);
    chk("stall_ex_pc",    64'(bus.pc), 64'd9);
    step();
    chk("stall_total_pc", 64'(bus.pc), 64'd10);
    rom_ovr = 1'b0;

    // Reset asserted mid-EXEC with ex_ready=0
    bus.ex_ready = 1'b0;
    step(); step();
    chk("pre_rst_valid", 64'(bus.ir_valid), 64'd1);
    chk("pre_rst_pc",    64'(bus.pc), 64'd10);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_pc",     64'(bus.pc), 64'd0);
    chk("async_rst_valid",  64'(bus.ir_valid), 64'd0);
    chk("async_rst_opcode", 64'(bus.opcode), 64'd0);
    rom_mem[0] = mk(OP_JMP, 4'h0, OT_NONE, 8'h00, OT_NONE, 8'h00, 8'hFF);
    step();
    chk("held_rst_pc",    64'(bus.pc), 64'd0);
    chk("held_rst_valid", 64'(bus.ir_valid), 64'd0);
    reset = 1'b0;
    bus.ex_ready   = 1'b1;
    bus.jump_taken = 1'b1;
    chk("post_rst_addr", 64'(bus.rom_addr), 64'd0);
    step();
    chk("post_rst_opcode", 64'(bus.opcode), 64'(OP_JMP));
    chk("post_rst_target", 64'(bus.target), 64'hFF);
    step(); step();
    chk("jmp_to_255", 64'(bus.pc), 64'd255);

    // Non-jump at 255 wraps to 0 even with jump_taken high
    step(); step();
    chk("pc255_valid", 64'(bus.ir_valid), 64'd1);
    chk("pc255_pc",    64'(bus.pc), 64'd255);
    step();
    chk("pc_wrap", 64'(bus.pc), 64'd0);

    // JMP to 20, then JMP at 20 targeting itself
    rom_mem[0] = mk(OP_JMP, 4'h0, OT_NONE, 8'h00, OT_NONE, 8'h00, 8'd20);
    step(); step(); step();
    chk("jmp_to_20", 64'(bus.pc), 64'd20);
    step(); step();
    chk("self_jmp_valid", 64'(bus.ir_valid), 64'd1);
    chk("self_jmp_pc",    64'(bus.pc), 64'd20);
    step();
    chk("self_jmp_addr",  64'(bus.rom_addr), 64'd20);
    chk("self_jmp_fetch", 64'(bus.ir_valid), 64'd0);
    step(); step();
    bus.jump_taken = 1'b0;
    step();
    chk("self_jmp_nt_pc", 64'(bus.pc), 64'd21);

    // Undefined opcode behaves as a non-jump
    bus.jump_taken = 1'b1;
    step(); step();
    chk("undef_valid",  64'(bus.ir_valid), 64'd1);
    chk("undef_opcode", 64'(bus.opcode), 64'd7);
    step();
    chk("undef_next_pc", 64'(bus.pc), 64'd22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_seq.md
# instr_fetch_seq

- Program-counter and fetch/decode sequencer for the X1 CPU.
- Drives the 8-bit address of the asynchronous program ROM, registers the returned 35-bit instruction word and splits it into fields.
- Hands each instruction to the execute datapath with a valid/ready handshake.
- Computes the next PC from the datapath's jump-condition result; sits directly upstream of the ROM address input and upstream of execute.

## Interface
- `ADDR_W`, 8: PC / ROM address width.
- `INSTR_W`, 35: instruction width. Layout: opcode[34:32], func[31:28], op1[27:18], op2[17:8], target[7:0]. An operand is {type[1:0], value[7:0]}.
- `RESET_PC`, 0: PC value after reset.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rom_addr`  out  8  address to the program ROM; equals `pc` at all times.
- `rom_data`  in  35  instruction word returned combinationally by the ROM.
- `stall`  in  1  freezes all sequencer state while high.
- `ex_ready`  in  1  execute accepts the presented instruction this cycle.
- `jump_taken`  in  1  condition result for the presented JMP; sampled only when the JMP is accepted.
- `pc`  out  8  address of the instruction being fetched or executed.
- `ir_valid`  out  1  instruction fields are valid and offered to execute.
- `opcode`  out  3  decoded opcode field.
- `func`  out  4  decoded function field.
- `op1_type` / `op1_val`  out  2 / 8  first operand.
- `op2_type` / `op2_val`  out  2 / 8  second operand.
- `target`  out  8  jump target field.

## Operation
- FSM states: FETCH, DECODE, EXEC.
- FETCH: `rom_addr` = `pc`. On the clock edge, `rom_data` is captured into IR. Next state is DECODE.
- DECODE: the field outputs are driven from IR.
  - If the opcode is NOP (all-zero word, which is every unprogrammed ROM location): `pc` <= `pc`+1 and the next state is FETCH.
  - Otherwise the next state is EXEC.
- EXEC: `ir_valid`=1 and the fields are held stable. The FSM stays in EXEC while `ex_ready`=0. When `ex_ready`=1:
  - If the opcode is JMP and `jump_taken`=1: `pc` <= `target`.
  - Otherwise: `pc` <= `pc`+1.
  - Next state is FETCH.
- The UNC jump condition is resolved by execute, which drives `jump_taken`=1. The sequencer does not decode conditions.
- PC arithmetic is modulo 2^8: 255+1 wraps to 0. A jump target may be any address, including `pc` itself.
- `stall`=1 blocks all register updates, including the IR capture and the PC update. `stall` takes priority over `ex_ready`. `ir_valid` stays asserted if the FSM is in EXEC.
- Opcode values that are not defined are treated as non-jump instructions: they go to EXEC, then `pc`+1.
- Reset (asynchronous, at any time, including mid-EXEC):
  - `pc`=`RESET_PC`, IR=0, state=FETCH, `ir_valid`=0.
  - All field outputs read 0.
  - The first fetch happens on the first clock edge after `reset` deasserts.

## Timing
- Non-NOP instruction: 3 cycles (FETCH, DECODE, EXEC) when `ex_ready`=1 in the first EXEC cycle. Each cycle of `ex_ready`=0 or `stall`=1 adds one cycle.
- NOP: 2 cycles.
- `ir_valid` rises in the cycle after DECODE. It is combinational from the state, with no glitch paths from the inputs.
- Jump redirect: the fetch of the target address happens in the cycle immediately after JMP acceptance. There is no delay slot.
- ROM path: `rom_addr` comes from a register, and `rom_data` must settle within the FETCH cycle.

## Structure
- Opcode, function, operand-type and NOP/N8/N10 constants live in the shared `CPU.vh` header.
- Field bit positions are defined there as localparam slices, used by both this block and execute.
- One natural sub-module, `instr_decode`: purely combinational IR-to-fields split plus the `is_nop`/`is_jmp` flags.
- The FSM, PC and IR live in the top level.

## Test plan
- Reset mid-EXEC with `ex_ready`=0 → next cycle `pc`=0 and `ir_valid`=0; after release, `rom_addr`=0 during FETCH.
- ROM with MOV at 0 and zeros at 1-3, `ex_ready`=1 → MOV presented in cycle 3, then `pc` steps 1, 2, 3, 4 at 2 cycles each with no `ir_valid`.
- JMP at 7 with target 4:
  - `jump_taken`=1 → `rom_addr`=4 in the cycle after acceptance.
  - `jump_taken`=0 → `rom_addr`=8.
- `ex_ready` held low 5 cycles on an ACC → `ir_valid` high for 6 cycles, fields constant, `pc` unchanged until acceptance.
- `stall`=1 during FETCH for 3 cycles with `rom_data` changing → IR captures the word present on the first unstalled edge; the total instruction time grows by 3.
- `pc`=255 holding a non-jump instruction → after acceptance `pc`=0. JMP at 20 with target 20 and `jump_taken`=1 → refetches 20.
